// File: rtl/dram_row_sched.sv
// dram_row_sched
// Per-request DRAM command sequencer. It takes one front-end request at a time,
// asks the row-open tracker for the bank's row state, and then issues the
// legal command sequence:
//   conflict          : PRE -> ACT -> RD/WR
//   miss / bank idle  : ACT -> RD/WR
//   hit               : RD/WR
// Refresh requests are arbitrated against new requests in IDLE only. A single
// down-counter enforces tRP, tRCD and tRFC.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request; a pending refresh wins
// LOOKUP   | one-cycle lookup strobe to the tracker
// DECIDE   | tracker status is valid; choose PRE, ACT or RD/WR
// PRE      | PRE issued to the conflicting open row
// WAIT_RP  | tRP spacing before ACT
// ACT      | ACT issued to the requested row, tracker told row is open
// WAIT_RCD | tRCD spacing before RD/WR
// RW       | RD or WR issued, request retired
// REF      | REF issued, refresh acknowledged
// WAIT_RFC | tRFC spacing before returning to IDLE
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_*_i / req_ready_o        front-end request handshake and fields
//   ref_req_i / ref_ack_o        refresh level request / one-cycle ack
//   trk_*_o / trk_*_i            row-open tracker lookup and notifications
//   cmd_*_o                      DRAM command strobe, opcode and target
//   done_o                       one-cycle pulse when a request retires

module dram_row_sched #(
  parameter int ROW_BITS = 15,
  parameter int COL_BITS = 10,
  parameter int T_RP     = 3,
  parameter int T_RCD    = 3,
  parameter int T_RFC    = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // front-end request
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic [1:0]          req_bg_i,
  input  logic [1:0]          req_bank_i,
  input  logic [ROW_BITS-1:0] req_row_i,
  input  logic [COL_BITS-1:0] req_col_i,
  // refresh
  input  logic                ref_req_i,
  output logic                ref_ack_o,
  // row-open tracker
  output logic                trk_req_en_o,
  output logic                trk_refresh_o,
  output logic                trk_row_resolve_o,
  output logic [1:0]          trk_bg_o,
  output logic [1:0]          trk_bank_o,
  output logic [ROW_BITS-1:0] trk_row_o,
  input  logic [1:0]          trk_row_stat_i,
  input  logic [ROW_BITS-1:0] trk_row_conflict_i,
  // command bus
  output logic                cmd_valid_o,
  output logic [2:0]          cmd_o,
  output logic [1:0]          cmd_bg_o,
  output logic [1:0]          cmd_bank_o,
  output logic [ROW_BITS-1:0] cmd_row_o,
  output logic [COL_BITS-1:0] cmd_col_o,
  output logic                done_o
);

  localparam int T_MAX_PR = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int T_MAX    = (T_MAX_PR > T_RFC) ? T_MAX_PR : T_RFC;
  localparam int CNT_W    = $clog2(T_MAX) + 1;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_PRE = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  localparam logic [1:0] STAT_HIT      = 2'b01;
  localparam logic [1:0] STAT_CONFLICT = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOOKUP   = 4'd1,
    S_DECIDE   = 4'd2,
    S_PRE      = 4'd3,
    S_WAIT_RP  = 4'd4,
    S_ACT      = 4'd5,
    S_WAIT_RCD = 4'd6,
    S_RW       = 4'd7,
    S_REF      = 4'd8,
    S_WAIT_RFC = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // latched request
  logic                wr_q, wr_d;
  logic [1:0]          bg_q, bg_d;
  logic [1:0]          bank_q, bank_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] conf_row_q, conf_row_d;

  // registered outputs
  logic                cmd_valid_q, cmd_valid_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [1:0]          cmd_bg_q, cmd_bg_d;
  logic [1:0]          cmd_bank_q, cmd_bank_d;
  logic [ROW_BITS-1:0] cmd_row_q, cmd_row_d;
  logic [COL_BITS-1:0] cmd_col_q, cmd_col_d;
  logic                trk_req_en_q, trk_req_en_d;
  logic                trk_resolve_q, trk_resolve_d;
  logic                ref_pulse_q, ref_pulse_d;
  logic [1:0]          trk_bg_q, trk_bg_d;
  logic [1:0]          trk_bank_q, trk_bank_d;
  logic [ROW_BITS-1:0] trk_row_q, trk_row_d;
  logic                done_q, done_d;

  logic                in_req_d;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      bg_q       <= '0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      conf_row_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      bg_q       <= bg_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      conf_row_q <= conf_row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    bg_d       = bg_q;
    bank_d     = bank_q;
    row_d      = row_q;
    col_d      = col_q;
    conf_row_d = conf_row_q;

    unique case (state_q)
      S_IDLE: begin
        if (ref_req_i) begin
          state_d = S_REF;
        end else if (req_valid_i) begin
          wr_d    = req_write_i;
          bg_d    = req_bg_i;
          bank_d  = req_bank_i;
          row_d   = req_row_i;
          col_d   = req_col_i;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_DECIDE;
      S_DECIDE: begin
        if (trk_row_stat_i == STAT_HIT) begin
          state_d = S_RW;
        end else if (trk_row_stat_i == STAT_CONFLICT) begin
          conf_row_d = trk_row_conflict_i;
          state_d    = S_PRE;
        end else begin
          state_d = S_ACT;
        end
      end
      S_PRE: begin
        cnt_d   = CNT_W'(T_RP - 1);
        state_d = S_WAIT_RP;
      end
      // Each wait exits on a count of 1 so the next command lands exactly
      // T cycles after the previous one; <= also guards against wrapping.
      S_WAIT_RP: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_ACT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACT: begin
        cnt_d   = CNT_W'(T_RCD - 1);
        state_d = S_WAIT_RCD;
      end
      S_WAIT_RCD: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_RW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RW: state_d = S_IDLE;
      S_REF: begin
        cnt_d   = CNT_W'(T_RFC - 1);
        state_d = S_WAIT_RFC;
      end
      S_WAIT_RFC: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Outputs are decoded from the next state and registered, so
  // they change together with the state register and never glitch.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_valid_d   = 1'b0;
    cmd_d         = CMD_NOP;
    cmd_bg_d      = '0;
    cmd_bank_d    = '0;
    cmd_row_d     = '0;
    cmd_col_d     = '0;
    trk_req_en_d  = 1'b0;
    trk_resolve_d = 1'b0;
    ref_pulse_d   = 1'b0;
    done_d        = 1'b0;

    in_req_d = (state_d == S_LOOKUP)  || (state_d == S_DECIDE) ||
               (state_d == S_PRE)     || (state_d == S_WAIT_RP) ||
               (state_d == S_ACT)     || (state_d == S_WAIT_RCD) ||
               (state_d == S_RW);

    // tracker address holds the latched request for the whole sequence
    trk_bg_d   = in_req_d ? bg_d   : '0;
    trk_bank_d = in_req_d ? bank_d : '0;
    trk_row_d  = in_req_d ? row_d  : '0;

    unique case (state_d)
      S_LOOKUP: trk_req_en_d = 1'b1;
      S_PRE: begin
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_PRE;
        cmd_bg_d    = bg_d;
        cmd_bank_d  = bank_d;
        cmd_row_d   = conf_row_d;
      end
      S_ACT: begin
        cmd_valid_d   = 1'b1;
        cmd_d         = CMD_ACT;
        cmd_bg_d      = bg_d;
        cmd_bank_d    = bank_d;
        cmd_row_d     = row_d;
        trk_resolve_d = 1'b1;
      end
      S_RW: begin
        cmd_valid_d = 1'b1;
        cmd_d       = wr_d ? CMD_WR : CMD_RD;
        cmd_bg_d    = bg_d;
        cmd_bank_d  = bank_d;
        cmd_col_d   = col_d;
        done_d      = 1'b1;
      end
      S_REF: begin
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_REF;
        ref_pulse_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_valid_q   <= 1'b0;
      cmd_q         <= CMD_NOP;
      cmd_bg_q      <= '0;
      cmd_bank_q    <= '0;
      cmd_row_q     <= '0;
      cmd_col_q     <= '0;
      trk_req_en_q  <= 1'b0;
      trk_resolve_q <= 1'b0;
      ref_pulse_q   <= 1'b0;
      trk_bg_q      <= '0;
      trk_bank_q    <= '0;
      trk_row_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      cmd_valid_q   <= cmd_valid_d;
      cmd_q         <= cmd_d;
      cmd_bg_q      <= cmd_bg_d;
      cmd_bank_q    <= cmd_bank_d;
      cmd_row_q     <= cmd_row_d;
      cmd_col_q     <= cmd_col_d;
      trk_req_en_q  <= trk_req_en_d;
      trk_resolve_q <= trk_resolve_d;
      ref_pulse_q   <= ref_pulse_d;
      trk_bg_q      <= trk_bg_d;
      trk_bank_q    <= trk_bank_d;
      trk_row_q     <= trk_row_d;
      done_q        <= done_d;
    end
  end

  // Ready is withheld while a refresh is pending so refresh wins a tie.
  assign req_ready_o       = (state_q == S_IDLE) && !ref_req_i;

  assign cmd_valid_o       = cmd_valid_q;
  assign cmd_o             = cmd_q;
  assign cmd_bg_o          = cmd_bg_q;
  assign cmd_bank_o        = cmd_bank_q;
  assign cmd_row_o         = cmd_row_q;
  assign cmd_col_o         = cmd_col_q;
  assign trk_req_en_o      = trk_req_en_q;
  assign trk_row_resolve_o = trk_resolve_q;
  assign trk_refresh_o     = ref_pulse_q;
  assign ref_ack_o         = ref_pulse_q;
  assign trk_bg_o          = trk_bg_q;
  assign trk_bank_o        = trk_bank_q;
  assign trk_row_o         = trk_row_q;
  assign done_o            = done_q;

endmodule
